scl180_sparecell_bank: RTL and testbench
========================================

// Module: scl180_sparecell_bank
// PURPOSE
//  Parametrised bank of NUM_GROUPS ECO spare-cell groups (nand/nor/inv chain + spare flop + tie-lo each) for the
//  SCL180 caravel top level. Adds a built-in toggle self-test: an LFSR drives all groups, a checker compares every
//  group against a golden model, and a MISR compacts responses. Idle groups sit at fixed static levels.
// PARAMETERS
//  NUM_GROUPS   4    spare groups instantiated; 1..LFSR_W/2
//  LFSR_W       16   LFSR/MISR width; fixed polynomial set for 16 only
//  TEST_CYCLES  256  RUN-state length in cycles; >=1, fits 16 bits
// PORTS
//  clock        in   1           single clock, all flops rising edge
//  resetn       in   1           synchronous active-low reset
//  test_start   in   1           level-sampled start request
//  test_busy    out  1           high in SEED/RUN/FLUSH
//  test_done    out  1           high in DONE
//  test_pass    out  1           valid when test_done; 1 = no mismatch
//  fail_map     out  NUM_GROUPS  sticky per-group mismatch flags
//  signature    out  LFSR_W      MISR value; final once test_done
//  LO           out  NUM_GROUPS  per-group tie-lo; constant 0
//  VPWR, VGND   inout 1          present only under `ifdef USE_POWER_PINS
// BEHAVIOUR
//  Reset (resetn=0 at edge): state=IDLE; LFSR=0; MISR=0; fail_map=0; all outputs 0; group flops 0.
//  FSM: IDLE -> SEED when test_start=1; SEED -> RUN (1 cycle, LFSR<=16'hACE1, MISR<=0, fail_map<=0);
//   RUN held TEST_CYCLES cycles (cycle counter 0..TEST_CYCLES-1) -> FLUSH (1 cycle, flop latency)
//   -> DONE; DONE -> SEED on test_start=1, otherwise holds results indefinitely.
//  test_start ignored in SEED/RUN/FLUSH. Start sampled at edge n => busy from n+1, done from n+TEST_CYCLES+3.
//  LFSR: Galois, right shift, taps 16'hB400, advances once per RUN cycle; frozen outside RUN.
//  Group g stimulus: a=lfsr[2g], b=lfsr[2g+1]; static a=b=0 outside RUN/FLUSH.
//  Group g function: c=~(a&b) (nand -> nor with tied inputs -> inv); q = c registered 1 cycle.
//  Checker: golden q_exp = ~(a&b) of previous cycle; compare q[g] in cycles RUN(>=1st)..FLUSH;
//   mismatch sets fail_map[g] (sticky until next SEED). test_pass = (fail_map==0) gated by test_done.
//  MISR: each compare cycle, misr <= galois_step(misr) ^ zero_ext({q[NUM_GROUPS-1:0]}); signature=misr.
//  Reset mid-operation returns to IDLE in one edge and clears all results; no partial result retained.
//  Simultaneous resetn=0 and test_start=1: reset wins.
//  Elaboration error if 2*NUM_GROUPS > LFSR_W or TEST_CYCLES==0.
// STRUCTURE
//  Package scl180_sparecell_pkg: state enum {IDLE,SEED,RUN,FLUSH,DONE}, LFSR_TAPS=16'hB400,
//   LFSR_SEED=16'hACE1, galois_step() function shared by LFSR, MISR and the bench model.
//  Sub-module scl180_sparecell_group: one group (nand2, nor2, inv, spare flop, conb tie-lo), ports
//   clock/resetn/a/b/c/q/LO; bank instantiates NUM_GROUPS copies via generate. FSM/LFSR/MISR/checker in bank.
//  Group cells carry dont_touch so synthesis keeps them as spares.
// TESTING
//  1 reset: hold resetn=0 3 cycles with test_start=1 -> all outputs 0, LO=0, busy=0.
//  2 clean run (defaults): start pulse at edge n -> busy n+1..n+258, done at n+259, pass=1, fail_map=0,
//    signature equals pkg-model MISR.
//  3 fault: force group 2 q stuck-0 during RUN -> done as in 2, pass=0, fail_map=4'b0100, signature differs.
//  4 start ignored: test_start held high throughout RUN -> single run, done timing unchanged.
//  5 reset mid-RUN at cycle 100 -> IDLE next edge, outputs 0; restart completes with same signature as 2.
//  6 restart from DONE with fault removed -> fail_map cleared in SEED, pass=1, signature identical to 2.

Source files
------------

// File: rtl/scl180_sparecell_pkg.sv
// Shared types, constants and the Galois step used by the spare-cell bank and its bench.
package scl180_sparecell_pkg;

    localparam int unsigned GALOIS_W = 16;

    localparam logic [GALOIS_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [GALOIS_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One right-shift Galois step; shared by the stimulus LFSR and the response MISR.
    function automatic logic [GALOIS_W-1:0] galois_step(input logic [GALOIS_W-1:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : {GALOIS_W{1'b0}});
    endfunction

endpackage

// File: rtl/scl180_sparecell_group.sv
// One ECO spare-cell group: nand2 -> nor2 (tied inputs) -> inv, a spare flop and a tie-lo.
module scl180_sparecell_group (
    input  logic clock,
    input  logic resetn,
    input  logic a,
    input  logic b,
    output logic c,
    output logic q,
    output logic LO
);

    (* dont_touch = "true" *) logic nand_out;
    (* dont_touch = "true" *) logic nor_out;

    // Spare gate chain; the nor with both inputs tied acts as an inverter.
    assign nand_out = ~(a & b);
    assign nor_out  = ~(nand_out | nand_out);
    assign c        = ~nor_out;

    // Spare flop capturing the chain output.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            q <= 1'b0;
        end else begin
            q <= c;
        end
    end

    // Tie-lo cell.
    assign LO = 1'b0;

endmodule

// File: rtl/scl180_sparecell_bank.sv
// Bank of spare-cell groups with an LFSR-driven toggle self-test, golden checker and MISR.
module scl180_sparecell_bank
    import scl180_sparecell_pkg::*;
#(
    parameter int unsigned NUM_GROUPS  = 4,
    parameter int unsigned LFSR_W      = 16,
    parameter int unsigned TEST_CYCLES = 256
) (
`ifdef USE_POWER_PINS
    inout  wire                   VPWR,
    inout  wire                   VGND,
`endif
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  test_start,
    output logic                  test_busy,
    output logic                  test_done,
    output logic                  test_pass,
    output logic [NUM_GROUPS-1:0] fail_map,
    output logic [LFSR_W-1:0]     signature,
    output logic [NUM_GROUPS-1:0] LO
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TEST_CYCLES - 1);

    // Reject parameter sets the fixed polynomial and stimulus mapping cannot support.
    if (LFSR_W != GALOIS_W) begin : g_bad_width
        $error("scl180_sparecell_bank: LFSR_W must be 16");
    end
    if ((NUM_GROUPS == 0) || (2 * NUM_GROUPS > LFSR_W)) begin : g_bad_groups
        $error("scl180_sparecell_bank: NUM_GROUPS must be 1..LFSR_W/2");
    end
    if (TEST_CYCLES == 0) begin : g_bad_cycles
        $error("scl180_sparecell_bank: TEST_CYCLES must be >= 1");
    end

    state_t                state;
    state_t                state_nxt;
    logic                  busy_d;
    logic                  done_d;
    logic                  pass_d;
    logic                  active_c;
    logic                  compare_c;
    logic [LFSR_W-1:0]     lfsr;
    logic [LFSR_W-1:0]     misr;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_GROUPS-1:0] a_vec;
    logic [NUM_GROUPS-1:0] b_vec;
    logic [NUM_GROUPS-1:0] c_vec;
    logic [NUM_GROUPS-1:0] q_vec;
    logic [NUM_GROUPS-1:0] exp_c;
    logic [NUM_GROUPS-1:0] q_exp;

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        active_c  = 1'b0;
        compare_c = 1'b0;
        case (state)
            IDLE: begin
                if (test_start) state_nxt = SEED;
            end
            SEED: begin
                busy_d    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy_d    = 1'b1;
                active_c  = 1'b1;
                compare_c = (cnt != '0);
                if (cnt == LAST_CNT) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy_d    = 1'b1;
                active_c  = 1'b1;
                compare_c = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_d = 1'b1;
                pass_d = (fail_map == '0);
                if (test_start) state_nxt = SEED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Group stimulus from the LFSR while testing, static zeros otherwise; golden chain output.
    always_comb begin
        a_vec = '0;
        b_vec = '0;
        if (active_c) begin
            for (int g = 0; g < int'(NUM_GROUPS); g++) begin
                a_vec[g] = lfsr[2*g];
                b_vec[g] = lfsr[2*g+1];
            end
        end
        exp_c = ~(a_vec & b_vec);
    end

    // LFSR, cycle counter, checker, MISR and registered status outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            lfsr      <= '0;
            misr      <= '0;
            cnt       <= '0;
            q_exp     <= '0;
            fail_map  <= '0;
            test_busy <= 1'b0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
        end else begin
            q_exp     <= exp_c;
            test_busy <= busy_d;
            test_done <= done_d;
            test_pass <= pass_d;
            if (state == SEED) begin
                lfsr     <= LFSR_SEED;
                misr     <= '0;
                cnt      <= '0;
                fail_map <= '0;
            end
            if (state == RUN) begin
                lfsr <= galois_step(lfsr);
                cnt  <= cnt + CNT_W'(1);
            end
            if (compare_c) begin
                fail_map <= fail_map | (q_vec ^ q_exp) | (c_vec ^ exp_c);
                misr     <= galois_step(misr) ^ LFSR_W'(q_vec);
            end
        end
    end

    assign signature = misr;

    // Spare-cell groups.
    for (genvar g = 0; g < int'(NUM_GROUPS); g++) begin : gen_group
        scl180_sparecell_group u_group (
            .clock  (clock),
            .resetn (resetn),
            .a      (a_vec[g]),
            .b      (b_vec[g]),
            .c      (c_vec[g]),
            .q      (q_vec[g]),
            .LO     (LO[g])
        );
    end

endmodule

// File: tb/tb_scl180_sparecell_bank.sv
// Directed self-checking bench for scl180_sparecell_bank at default parameters.
module tb_scl180_sparecell_bank;
    import scl180_sparecell_pkg::*;

    localparam int unsigned NG = 4;
    localparam int unsigned TC = 256;

    logic          clock;
    logic          resetn;
    logic          test_start;
    logic          test_busy;
    logic          test_done;
    logic          test_pass;
    logic [NG-1:0] fail_map;
    logic [15:0]   signature;
    logic [NG-1:0] LO;

    int n_checks;
    int n_fail;

    logic [15:0] sig_clean;
    logic [15:0] sig_fault;

    scl180_sparecell_bank #(
        .NUM_GROUPS  (NG),
        .LFSR_W      (16),
        .TEST_CYCLES (TC)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .test_start (test_start),
        .test_busy  (test_busy),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .fail_map   (fail_map),
        .signature  (signature),
        .LO         (LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference signature: TC responses c_0..c_{TC-1}, optional stuck-at-0 groups.
    function automatic logic [15:0] model_sig(input logic [NG-1:0] stuck0);
        logic [15:0]   l;
        logic [15:0]   m;
        logic [NG-1:0] c;
        l = LFSR_SEED;
        m = 16'h0000;
        for (int j = 0; j < int'(TC); j++) begin
            for (int g = 0; g < int'(NG); g++) c[g] = ~(l[2*g] & l[2*g+1]);
            c = c & ~stuck0;
            m = galois_step(m) ^ {12'h000, c};
            l = galois_step(l);
        end
        return m;
    endfunction

    // Start one test and step through it, recording busy/done timing relative to the start edge.
    task automatic run_test(input bit hold, output int busy_cnt, output bit done_ok,
                            output logic [NG-1:0] fm_early);
        busy_cnt = 0;
        done_ok  = 1'b0;
        fm_early = 'x;
        @(negedge clock);
        test_start = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) test_start = 1'b0;
        for (int i = 1; i <= int'(TC) + 3; i++) begin
            @(posedge clock);
            #1;
            if (i == 1) fm_early = fail_map;
            if (i <= int'(TC) + 2 && test_busy === 1'b1 && test_done === 1'b0) busy_cnt++;
            if (i == int'(TC) + 3) done_ok = (test_done === 1'b1 && test_busy === 1'b0);
            if (hold && i == int'(TC)) test_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        test_start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (test_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", test_busy); end
        n_checks++; if (test_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", test_done); end
        n_checks++; if (test_pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b expected 0", test_pass); end
        n_checks++; if (fail_map !== 4'b0000) begin n_fail++; $display("FAIL reset_fail_map: got %b expected 0000", fail_map); end
        n_checks++; if (signature !== 16'h0000) begin n_fail++; $display("FAIL reset_signature: got %h expected 0000", signature); end
        n_checks++; if (LO !== 4'b0000) begin n_fail++; $display("FAIL reset_lo: got %b expected 0000", LO); end
        test_start = 1'b0;
        resetn     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (test_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", test_busy); end
    endtask

    task automatic test_clean_run();
        int          bc;
        bit          dok;
        logic [NG-1:0] fe;
        run_test(1'b0, bc, dok, fe);
        sig_clean = signature;
        n_checks++; if (bc != int'(TC) + 2) begin n_fail++; $display("FAIL clean_busy_cycles: got %0d expected %0d", bc, TC + 2); end
        n_checks++; if (dok !== 1'b1) begin n_fail++; $display("FAIL clean_done_edge: got %b expected 1", dok); end
        n_checks++; if (test_pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b expected 1", test_pass); end
        n_checks++; if (fail_map !== 4'b0000) begin n_fail++; $display("FAIL clean_fail_map: got %b expected 0000", fail_map); end
        n_checks++; if (signature !== model_sig(4'b0000)) begin n_fail++; $display("FAIL clean_signature: got %h expected %h", signature, model_sig(4'b0000)); end
        n_checks++; if (LO !== 4'b0000) begin n_fail++; $display("FAIL clean_lo: got %b expected 0000", LO); end
    endtask

    task automatic test_start_ignored();
        int          bc;
        bit          dok;
        logic [NG-1:0] fe;
        run_test(1'b1, bc, dok, fe);
        n_checks++; if (bc != int'(TC) + 2) begin n_fail++; $display("FAIL held_busy_cycles: got %0d expected %0d", bc, TC + 2); end
        n_checks++; if (dok !== 1'b1) begin n_fail++; $display("FAIL held_done_edge: got %b expected 1", dok); end
        n_checks++; if (signature !== model_sig(4'b0000)) begin n_fail++; $display("FAIL held_signature: got %h expected %h", signature, model_sig(4'b0000)); end
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (test_done !== 1'b1 || test_busy !== 1'b0) begin n_fail++; $display("FAIL held_done_holds: got done=%b busy=%b expected done=1 busy=0", test_done, test_busy); end
    endtask

    task automatic test_fault();
        int          bc;
        bit          dok;
        logic [NG-1:0] fe;
        force dut.gen_group[2].u_group.q = 1'b0;
        run_test(1'b0, bc, dok, fe);
        release dut.gen_group[2].u_group.q;
        sig_fault = signature;
        n_checks++; if (bc != int'(TC) + 2) begin n_fail++; $display("FAIL fault_busy_cycles: got %0d expected %0d", bc, TC + 2); end
        n_checks++; if (dok !== 1'b1) begin n_fail++; $display("FAIL fault_done_edge: got %b expected 1", dok); end
        n_checks++; if (test_pass !== 1'b0) begin n_fail++; $display("FAIL fault_pass: got %b expected 0", test_pass); end
        n_checks++; if (fail_map !== 4'b0100) begin n_fail++; $display("FAIL fault_fail_map: got %b expected 0100", fail_map); end
        n_checks++; if (signature !== model_sig(4'b0100)) begin n_fail++; $display("FAIL fault_signature: got %h expected %h", signature, model_sig(4'b0100)); end
        n_checks++; if (sig_fault === sig_clean) begin n_fail++; $display("FAIL fault_sig_differs: got %h expected not %h", sig_fault, sig_clean); end
    endtask

    task automatic test_restart_from_done();
        int          bc;
        bit          dok;
        logic [NG-1:0] fe;
        run_test(1'b0, bc, dok, fe);
        n_checks++; if (fe !== 4'b0000) begin n_fail++; $display("FAIL restart_fail_map_cleared: got %b expected 0000", fe); end
        n_checks++; if (dok !== 1'b1) begin n_fail++; $display("FAIL restart_done_edge: got %b expected 1", dok); end
        n_checks++; if (test_pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass: got %b expected 1", test_pass); end
        n_checks++; if (fail_map !== 4'b0000) begin n_fail++; $display("FAIL restart_fail_map: got %b expected 0000", fail_map); end
        n_checks++; if (signature !== model_sig(4'b0000)) begin n_fail++; $display("FAIL restart_signature: got %h expected %h", signature, model_sig(4'b0000)); end
    endtask

    task automatic test_reset_mid_run();
        int          bc;
        bit          dok;
        logic [NG-1:0] fe;
        @(negedge clock);
        test_start = 1'b1;
        @(posedge clock);
        #1;
        test_start = 1'b0;
        repeat (101) @(posedge clock);
        #1;
        n_checks++; if (test_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", test_busy); end
        resetn = 1'b0;
        test_start = 1'b1;
        @(posedge clock);
        #1;
        n_checks++; if (test_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", test_busy); end
        n_checks++; if (test_done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b expected 0", test_done); end
        n_checks++; if (test_pass !== 1'b0) begin n_fail++; $display("FAIL mid_pass: got %b expected 0", test_pass); end
        n_checks++; if (fail_map !== 4'b0000) begin n_fail++; $display("FAIL mid_fail_map: got %b expected 0000", fail_map); end
        n_checks++; if (signature !== 16'h0000) begin n_fail++; $display("FAIL mid_signature: got %h expected 0000", signature); end
        test_start = 1'b0;
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (test_busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy: got %b expected 0", test_busy); end
        run_test(1'b0, bc, dok, fe);
        n_checks++; if (dok !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_done_edge: got %b expected 1", dok); end
        n_checks++; if (signature !== model_sig(4'b0000)) begin n_fail++; $display("FAIL mid_rerun_signature: got %h expected %h", signature, model_sig(4'b0000)); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        test_start = 1'b0;
        test_reset();
        test_clean_run();
        test_start_ignored();
        test_fault();
        test_restart_from_done();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
